// File: rtl/knn_dist_calc.sv
// knn_dist_calc: streams labelled 2-D points against a latched test point and
// emits the saturated squared Euclidean distance of each accepted point three
// cycles after acceptance. Query control is IDLE -> RUN -> DRAIN -> IDLE.
module knn_dist_calc #(
   parameter int COORD_W = 16,
   parameter int DATA_W  = 32,
   parameter int LABEL   = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CNT_W-1:0]   n_points,
   input  logic [COORD_W-1:0] test_x,
   input  logic [COORD_W-1:0] test_y,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   input  logic [LABEL-1:0]   in_label,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [DATA_W-1:0]  Dist_candidate,
   output logic [LABEL-1:0]   label_candidate,
   output logic               valid,
   output logic               busy,
   output logic               done
);

   localparam int DIFF_W = COORD_W + 1;
   localparam int PROD_W = 2 * DIFF_W;
   localparam int SUM_W  = PROD_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    n_q, n_d, acc_q, acc_d;
   logic [COORD_W-1:0]  tx_q, tx_d, ty_q, ty_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                accept_s;

   // Pipeline: S1 differences, S2 squares, S3 saturated sum (output regs).
   logic [DIFF_W-1:0]   dx_s, dy_s;
   logic [PROD_W-1:0]   dx_ext_s, dy_ext_s;
   logic [SUM_W-1:0]    sum_s;
   logic [DATA_W-1:0]   dist_s;
   logic [DIFF_W-1:0]   s1_dx_q, s1_dy_q;
   logic [LABEL-1:0]    s1_lbl_q, s2_lbl_q, lbl_q;
   logic                s1_v_q, s2_v_q, valid_q;
   logic [PROD_W-1:0]   s2_sx_q, s2_sy_q;
   logic [DATA_W-1:0]   dist_q;

   // in_ready_q is only ever high in RUN, so this alone qualifies an accept.
   assign accept_s = in_valid & in_ready_q;

   // Two's-complement differences, one bit wider so no overflow is possible.
   assign dx_s = {in_x[COORD_W-1], in_x} - {tx_q[COORD_W-1], tx_q};
   assign dy_s = {in_y[COORD_W-1], in_y} - {ty_q[COORD_W-1], ty_q};

   // Sign-extend to the product width; the square is non-negative and fits.
   assign dx_ext_s = {{DIFF_W{s1_dx_q[DIFF_W-1]}}, s1_dx_q};
   assign dy_ext_s = {{DIFF_W{s1_dy_q[DIFF_W-1]}}, s1_dy_q};
   assign sum_s    = {1'b0, s2_sx_q} + {1'b0, s2_sy_q};

   // Clamp the sum to the largest representable distance.
   always_comb begin
      dist_s = sum_s[DATA_W-1:0];
      if (sum_s[SUM_W-1:DATA_W] != {(SUM_W-DATA_W){1'b0}}) begin
         dist_s = {DATA_W{1'b1}};
      end else begin
         dist_s = sum_s[DATA_W-1:0];
      end
   end

   // Next-state and control outputs of the query FSM.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      acc_d   = acc_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               tx_d    = test_x;
               ty_d    = test_y;
               n_d     = n_points;
               acc_d   = {CNT_W{1'b0}};
               busy_d  = 1'b1;
               state_d = (n_points == {CNT_W{1'b0}}) ? DRAIN : RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (accept_s) begin
               acc_d = acc_q + CNT_W'(1);
               if ((acc_q + CNT_W'(1)) == n_q) begin
                  state_d = DRAIN;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            // done_q high means the pulse is out; return to IDLE next.
            if (done_q) begin
               state_d = IDLE;
            end else if (!s1_v_q && !s2_v_q) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
      in_ready_d = (state_d == RUN) && (acc_d < n_d);
   end

   // Query control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= {CNT_W{1'b0}};
         acc_q      <= {CNT_W{1'b0}};
         tx_q       <= {COORD_W{1'b0}};
         ty_q       <= {COORD_W{1'b0}};
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         acc_q      <= acc_d;
         tx_q       <= tx_d;
         ty_q       <= ty_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Three-stage distance pipeline; outputs hold their value between valids.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q   <= 1'b0;
         s1_dx_q  <= {DIFF_W{1'b0}};
         s1_dy_q  <= {DIFF_W{1'b0}};
         s1_lbl_q <= {LABEL{1'b0}};
         s2_v_q   <= 1'b0;
         s2_sx_q  <= {PROD_W{1'b0}};
         s2_sy_q  <= {PROD_W{1'b0}};
         s2_lbl_q <= {LABEL{1'b0}};
         valid_q  <= 1'b0;
         dist_q   <= {DATA_W{1'b0}};
         lbl_q    <= {LABEL{1'b0}};
      end else begin
         s1_v_q   <= accept_s;
         s1_dx_q  <= dx_s;
         s1_dy_q  <= dy_s;
         s1_lbl_q <= in_label;
         s2_v_q   <= s1_v_q;
         s2_sx_q  <= dx_ext_s * dx_ext_s;
         s2_sy_q  <= dy_ext_s * dy_ext_s;
         s2_lbl_q <= s1_lbl_q;
         valid_q  <= s2_v_q;
         if (s2_v_q) begin
            dist_q <= dist_s;
            lbl_q  <= s2_lbl_q;
         end
      end
   end

   assign in_ready        = in_ready_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign valid           = valid_q;
   assign Dist_candidate  = dist_q;
   assign label_candidate = lbl_q;

endmodule

// File: tb/tb_knn_dist_calc.sv
// Self-checking bench for knn_dist_calc: directed scenarios plus randomized
// back-to-back queries checked against a plain-arithmetic reference model.
module tb_knn_dist_calc;

   logic        clk = 1'b0;
   logic        rst, start, in_valid;
   logic [15:0] n_points, test_x, test_y, in_x, in_y;
   logic [7:0]  in_label;
   logic        in_ready, valid, busy, done;
   logic [31:0] Dist_candidate;
   logic [7:0]  label_candidate;

   knn_dist_calc dut (
      .clk(clk), .rst(rst), .start(start), .n_points(n_points),
      .test_x(test_x), .test_y(test_y), .in_x(in_x), .in_y(in_y),
      .in_label(in_label), .in_valid(in_valid), .in_ready(in_ready),
      .Dist_candidate(Dist_candidate), .label_candidate(label_candidate),
      .valid(valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          c;
      logic [31:0] d;
      logic [7:0]  l;
   } ev_t;

   ev_t obs_q[$], exp_q[$];
   int  done_q[$];
   bit  busy_at[8192];
   int  px[$], py[$], pl[$];
   bit  pv[$], rdy_obs[$], rdy_exp[$];
   int  gl_idx = -1;
   int  n_cmp = 0, n_bad = 0;

   // Output monitor, sampled mid-cycle.
   always @(negedge clk) begin
      busy_at[cyc % 8192] <= busy;
      if (valid) obs_q.push_back('{c: cyc, d: Dist_candidate, l: label_candidate});
      if (done) done_q.push_back(cyc);
   end

   function automatic logic [31:0] ref_dist(int tx, int ty, int x, int y);
      longint dx = longint'(x) - longint'(tx);
      longint dy = longint'(y) - longint'(ty);
      longint s  = dx * dx + dy * dy;
      return (s > 64'sd4294967295) ? 32'hFFFF_FFFF : 32'(s);
   endfunction

   // Drives one query from px/py/pl/pv and builds the expected stream.
   task automatic run_query(input int tx, input int ty, input int n,
                            output int c0, output int ed);
      int cnt, last;
      obs_q.delete(); done_q.delete(); exp_q.delete();
      rdy_obs.delete(); rdy_exp.delete();
      @(posedge clk); #1;
      start = 1'b1; test_x = 16'(tx); test_y = 16'(ty); n_points = 16'(n);
      in_valid = 1'b0; c0 = cyc; cnt = 0; last = c0;
      foreach (px[i]) begin
         @(posedge clk); #1;
         start = (i == gl_idx);
         if (start) begin
            test_x = ~test_x; test_y = test_y + 16'd3; n_points = n_points + 16'd5;
         end
         in_x = 16'(px[i]); in_y = 16'(py[i]); in_label = 8'(pl[i]); in_valid = pv[i];
         rdy_obs.push_back(in_ready);
         rdy_exp.push_back(cnt < n);
         if (pv[i] && cnt < n) begin
            exp_q.push_back('{c: cyc + 3, d: ref_dist(tx, ty, px[i], py[i]), l: 8'(pl[i])});
            cnt++;
            last = cyc;
         end
      end
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;
      ed = (n == 0) ? c0 + 2 : last + 4;
      for (int k = 0; k < 60 && cyc < ed; k++) begin
         @(posedge clk); #1;
      end
      @(negedge clk); #1;
   endtask

   task automatic clear_pts();
      px.delete(); py.delete(); pl.delete(); pv.delete();
   endtask

   task automatic add_pt(input int x, input int y, input int l, input bit v);
      px.push_back(x); py.push_back(y); pl.push_back(l); pv.push_back(v);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; n_points = 16'd0;
      test_x = 16'd0; test_y = 16'd0; in_x = 16'd0; in_y = 16'd0; in_label = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      n_cmp++; if (Dist_candidate !== 32'd0) begin n_bad++; $display("FAIL reset_dist got %0h want 0", Dist_candidate); end
      n_cmp++; if (label_candidate !== 8'd0) begin n_bad++; $display("FAIL reset_label got %0h want 0", label_candidate); end
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int c0, ed;
      clear_pts(); add_pt(3, 4, 7, 1'b1);
      run_query(0, 0, 1, c0, ed);
      n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL single_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         n_cmp++; if (obs_q[0].c != c0 + 4) begin n_bad++; $display("FAIL single_latency got cyc %0d want %0d", obs_q[0].c, c0 + 4); end
         n_cmp++; if (obs_q[0].d !== 32'd25) begin n_bad++; $display("FAIL single_dist got %0d want 25", obs_q[0].d); end
         n_cmp++; if (obs_q[0].l !== 8'd7) begin n_bad++; $display("FAIL single_label got %0d want 7", obs_q[0].l); end
      end
      n_cmp++; if (done_q.size() != 1 || done_q[0] != c0 + 5) begin n_bad++; $display("FAIL single_done got %0d pulses want 1 at %0d", done_q.size(), c0 + 5); end
      n_cmp++; if (busy_at[(c0 + 1) % 8192] !== 1'b1) begin n_bad++; $display("FAIL single_busy_hi got 0 want 1"); end
      n_cmp++; if (busy_at[(c0 + 5) % 8192] !== 1'b0) begin n_bad++; $display("FAIL single_busy_done got 1 want 0"); end
   endtask

   task automatic test_stream();
      int c0, ed;
      logic [31:0] want [4];
      want[0] = 32'd0; want[1] = 32'd1; want[2] = 32'd25; want[3] = 32'd800;
      clear_pts();
      add_pt(10, -10, 11, 1'b1); add_pt(11, -10, 12, 1'b1);
      add_pt(7, -6, 13, 1'b1);   add_pt(-10, 10, 14, 1'b1);
      add_pt(1, 1, 15, 1'b1);
      run_query(10, -10, 4, c0, ed);
      n_cmp++; if (obs_q.size() != 4) begin n_bad++; $display("FAIL stream_count got %0d want 4", obs_q.size()); end
      for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i].c != c0 + 4 + i || obs_q[i].d !== want[i] || obs_q[i].l !== 8'(11 + i)) begin
            n_bad++;
            $display("FAIL stream_%0d got cyc %0d d %0d l %0d want cyc %0d d %0d l %0d",
                     i, obs_q[i].c, obs_q[i].d, obs_q[i].l, c0 + 4 + i, want[i], 11 + i);
         end
      end
      n_cmp++; if (rdy_obs[3] !== 1'b1) begin n_bad++; $display("FAIL stream_ready4 got 0 want 1"); end
      n_cmp++; if (rdy_obs[4] !== 1'b0) begin n_bad++; $display("FAIL stream_ready_drop got 1 want 0"); end
      n_cmp++; if (done_q.size() != 1 || done_q[0] != c0 + 8) begin n_bad++; $display("FAIL stream_done got %0d pulses want 1 at %0d", done_q.size(), c0 + 8); end
   endtask

   task automatic test_saturate();
      int c0, ed;
      clear_pts(); add_pt(32767, 32767, 99, 1'b1);
      run_query(-32768, -32768, 1, c0, ed);
      n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL sat_count got %0d want 1", obs_q.size()); end
      if (obs_q.size() > 0) begin
         n_cmp++; if (obs_q[0].d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_dist got %0h want ffffffff", obs_q[0].d); end
      end
   endtask

   task automatic test_bubbles();
      int c0, ed;
      clear_pts();
      add_pt(5, -3, 1, 1'b1); add_pt(0, 0, 2, 1'b0); add_pt(-200, 40, 3, 1'b1);
      add_pt(9, 9, 4, 1'b0);  add_pt(1000, -7, 5, 1'b1); add_pt(6, 6, 6, 1'b1);
      run_query(17, -23, 3, c0, ed);
      n_cmp++; if (obs_q.size() != 3) begin n_bad++; $display("FAIL bubble_count got %0d want 3", obs_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i].c != exp_q[i].c || obs_q[i].d !== exp_q[i].d || obs_q[i].l !== exp_q[i].l) begin
            n_bad++;
            $display("FAIL bubble_%0d got cyc %0d d %0d l %0d want cyc %0d d %0d l %0d",
                     i, obs_q[i].c, obs_q[i].d, obs_q[i].l, exp_q[i].c, exp_q[i].d, exp_q[i].l);
         end
      end
      n_cmp++; if (rdy_obs[5] !== 1'b0) begin n_bad++; $display("FAIL bubble_extra_ready got 1 want 0"); end
      n_cmp++; if (done_q.size() != 1) begin n_bad++; $display("FAIL bubble_done got %0d pulses want 1", done_q.size()); end
   endtask

   task automatic test_zero_and_ignore();
      int c0, ed;
      clear_pts(); add_pt(1, 1, 1, 1'b0);
      run_query(3, 3, 0, c0, ed);
      n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL zero_valid got %0d want 0", obs_q.size()); end
      n_cmp++; if (done_q.size() != 1 || done_q[0] != c0 + 2) begin n_bad++; $display("FAIL zero_done got %0d pulses want 1 at %0d", done_q.size(), c0 + 2); end
      n_cmp++; if (busy_at[(c0 + 1) % 8192] !== 1'b1) begin n_bad++; $display("FAIL zero_busy got 0 want 1"); end
      n_cmp++; if (busy_at[(c0 + 2) % 8192] !== 1'b0) begin n_bad++; $display("FAIL zero_busy_done got 1 want 0"); end
      clear_pts();
      for (int i = 0; i < 6; i++) add_pt(i * 37 - 90, 50 - i * 13, 40 + i, 1'b1);
      gl_idx = 1;
      run_query(-5, 7, 4, c0, ed);
      gl_idx = -1;
      n_cmp++; if (obs_q.size() != 4) begin n_bad++; $display("FAIL ignore_count got %0d want 4", obs_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i].d !== exp_q[i].d || obs_q[i].c != exp_q[i].c) begin
            n_bad++;
            $display("FAIL ignore_%0d got d %0d cyc %0d want d %0d cyc %0d", i, obs_q[i].d, obs_q[i].c, exp_q[i].d, exp_q[i].c);
         end
      end
      n_cmp++; if (done_q.size() != 1) begin n_bad++; $display("FAIL ignore_done got %0d pulses want 1", done_q.size()); end
   endtask

   task automatic test_rst_mid();
      int c0;
      obs_q.delete(); done_q.delete();
      @(posedge clk); #1;
      start = 1'b1; test_x = 16'd100; test_y = 16'd50; n_points = 16'd5; c0 = cyc;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_x = 16'd1; in_y = 16'd2; in_label = 8'd1;
      @(posedge clk); #1;
      in_x = 16'd3; in_label = 8'd2;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready got %b want 0", in_ready); end
      repeat (6) @(posedge clk);
      @(negedge clk); #1;
      n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rstmid_no_valid got %0d want 0", obs_q.size()); end
      n_cmp++; if (done_q.size() != 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d want 0", done_q.size()); end
      n_cmp++; if (busy_at[(c0 + 6) % 8192] !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_later got 1 want 0"); end
   endtask

   task automatic test_random_back_to_back();
      int c0, ed, n, acc, tx, ty;
      bit v;
      for (int it = 0; it < 8; it++) begin
         tx = int'($urandom_range(0, 65535)) - 32768;
         ty = int'($urandom_range(0, 65535)) - 32768;
         n  = int'($urandom_range(1, 6));
         clear_pts();
         acc = 0;
         while (acc < n) begin
            v = ($urandom_range(0, 3) != 0);
            add_pt(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                   int'($urandom_range(0, 255)), v);
            if (v) acc++;
         end
         add_pt(0, 0, 0, 1'b1);
         run_query(tx, ty, n, c0, ed);
         n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand%0d_count got %0d want %0d", it, obs_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].c != exp_q[i].c || obs_q[i].d !== exp_q[i].d || obs_q[i].l !== exp_q[i].l) begin
               n_bad++;
               $display("FAIL rand%0d_%0d got cyc %0d d %0h l %0d want cyc %0d d %0h l %0d", it, i,
                        obs_q[i].c, obs_q[i].d, obs_q[i].l, exp_q[i].c, exp_q[i].d, exp_q[i].l);
            end
         end
         for (int i = 0; i < rdy_exp.size(); i++) begin
            n_cmp++;
            if (rdy_obs[i] !== rdy_exp[i]) begin
               n_bad++;
               $display("FAIL rand%0d_ready%0d got %b want %b", it, i, rdy_obs[i], rdy_exp[i]);
            end
         end
         n_cmp++; if (done_q.size() != 1 || done_q[0] != ed) begin n_bad++; $display("FAIL rand%0d_done got %0d pulses want 1 at %0d", it, done_q.size(), ed); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_saturate();
      test_bubbles();
      test_zero_and_ignore();
      test_rst_mid();
      test_random_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/knn_dist_calc.md
Name: knn_dist_calc

Overview:
- Upstream feeder of the KNN sorted-list elements: computes the squared Euclidean distance between a latched test point and a stream of labelled dataset points.
- Emits one (Dist_candidate, label_candidate, valid) triple per accepted point, broadcast to every list element in the same cycle.
- Counts points per query, raises `done` once the last distance has been emitted, and gates the list via `busy`.

Parameters:
- COORD_W, 16, signed coordinate width (two's complement)
- DATA_W, 32, distance width; saturating unsigned result
- LABEL, 8, label width
- CNT_W, 16, point-count width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches test point and n_points, begins a query
- n_points  in  CNT_W  number of dataset points in this query
- test_x  in  COORD_W  test point x, sampled on start
- test_y  in  COORD_W  test point y, sampled on start
- in_x  in  COORD_W  dataset point x
- in_y  in  COORD_W  dataset point y
- in_label  in  LABEL  dataset point label
- in_valid  in  1  dataset point present
- in_ready  out  1  block accepts a point this cycle
- Dist_candidate  out  DATA_W  squared distance
- label_candidate  out  LABEL  label of that point
- valid  out  1  Dist_candidate/label_candidate valid this cycle
- busy  out  1  query in progress (drives list `start`)
- done  out  1  one-cycle pulse after the last valid of a query

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high. Reset clears all registers.
- Reset values: in_ready=0, Dist_candidate=0, label_candidate=0, valid=0, busy=0, done=0, state=IDLE, counters=0.
- FSM IDLE -> RUN -> DRAIN -> IDLE:
  - IDLE: start=1 latches test_x, test_y and n_points, clears acc_cnt, and sets busy=1 on the next cycle. Next state is RUN, or DRAIN if n_points=0.
  - RUN: in_ready=1 while acc_cnt<n_points. A point is accepted when in_valid&in_ready, and acc_cnt increments. When the last point is accepted (acc_cnt+1==n_points), the next state is DRAIN and in_ready drops on the next cycle.
  - DRAIN: wait until all pipeline valid bits are 0. Then pulse done=1 for one cycle, set busy=0 in that same cycle, and go to IDLE.
  - start outside IDLE is ignored; the latched test point and n_points stay stable.
- Pipeline: three stages, no backpressure (list elements always consume).
  - S1: dx=in_x-test_x, dy=in_y-test_y, each COORD_W+1 bits signed.
  - S2: sx=dx*dx, sy=dy*dy, each 2*(COORD_W+1) bits unsigned.
  - S3: sum=sx+sy; Dist_candidate=min(sum, 2^DATA_W-1) (saturate).
  - Label and a valid bit travel with each stage.
- Latency: a point accepted in cycle t has valid=1 in cycle t+3. Throughput is 1 point/cycle.
- valid=0 cycles leave Dist_candidate/label_candidate holding their last values; consumers qualify with valid.
- Bubble: in_valid=0 in RUN inserts a valid=0 bubble; the count does not advance.
- n_points=0: start -> busy=1 for one cycle -> done pulse; no valid is emitted.
- Exactly n_points valid pulses are emitted per query. Points offered after acc_cnt reaches n_points are not accepted (in_ready=0).
- Back-to-back queries: start is honoured in the same cycle the FSM returns to IDLE (the cycle after done).
- rst mid-query: all pipeline valids are cleared on the next edge; no valid or done is emitted for the aborted query.

Test Plan:
- Reset then start with test=(0,0), n_points=1, point (3,4,label 7) -> valid=1 exactly 3 cycles after accept, Dist_candidate=25, label_candidate=7, done on the following cycle, busy=0.
- test=(10,-10), n_points=4, points streamed on consecutive cycles: (10,-10), (11,-10), (7,-6), (-10,10) -> Dist_candidate sequence 0, 1, 25, 800 on consecutive cycles with labels preserved; in_ready drops after the 4th accept.
- Saturation: test=(-32768,-32768), point (32767,32767) -> sum=2*65535^2 exceeds 2^32-1 -> Dist_candidate=0xFFFFFFFF.
- n_points=3 with in_valid toggling 1,0,1,0,1 -> exactly 3 valid pulses with bubbles matching the gaps; a 4th point offered is not accepted; exactly one done pulse.
- n_points=0 -> no valid, done pulse 2 cycles after start. A second start during RUN is ignored: count and test point are unchanged.
- rst asserted 1 cycle after the 2nd accept of a 5-point query -> valid=0, done=0, busy=0 from the next edge on. A new query then runs correctly.
